// File: rtl/dbg_pkg.sv
// Shared widths and trace-entry layout for the pipeline-stage debug trace path.
// The status word bit order is {spmm_vld, spmm_rdy, dmvm_vld, dmvm_rdy, sm_vld, sm_rdy, aggr_vld, aggr_rdy}.
package dbg_pkg;

    localparam int DBG_STATUS_W = 8;
    localparam int DBG_TS_W     = 24;
    localparam int DBG_WORD_W   = 32;

    localparam int BIT_SPMM_VLD = 7;
    localparam int BIT_SPMM_RDY = 6;
    localparam int BIT_DMVM_VLD = 5;
    localparam int BIT_DMVM_RDY = 4;
    localparam int BIT_SM_VLD   = 3;
    localparam int BIT_SM_RDY   = 2;
    localparam int BIT_AGGR_VLD = 1;
    localparam int BIT_AGGR_RDY = 0;

    typedef struct packed {
        logic [DBG_STATUS_W-1:0] status;
        logic [DBG_TS_W-1:0]     ts;
    } trace_entry_t;

endpackage

// File: rtl/dbg_sync_fifo.sv
// First-word-fall-through synchronous FIFO with occupancy count and synchronous flush.
// The head word reads as zero while empty so no stale entry is ever presented.
module dbg_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clr_i,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           data_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           data_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_pop  = pop_i && !empty_o && !clr_i;
    // A push into a full FIFO is legal only when the head leaves in the same cycle.
    assign do_push = push_i && (!full_o || do_pop) && !clr_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clr_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            if (do_push && !do_pop)      count_d = count_q + 1'b1;
            else if (!do_push && do_pop) count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= data_i;
    end

    assign data_o  = empty_o ? '0 : mem[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/debug_trace_buffer.sv
// Timestamps every change of the stage-status word and queues it for the host.
// Events arriving with the FIFO full and no pop are dropped and counted.
module debug_trace_buffer
    import dbg_pkg::*;
#(
    parameter int STATUS_W = DBG_STATUS_W,
    parameter int TS_W     = DBG_TS_W,
    parameter int DEPTH    = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [STATUS_W-1:0]      status_i,
    input  logic                     enable_i,
    input  logic                     clear_i,
    output logic                     rd_vld_o,
    input  logic                     rd_rdy_i,
    output logic [DBG_WORD_W-1:0]    rd_data_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     overflow_o,
    output logic [15:0]              drop_cnt_o,
    output logic                     ts_wrap_o
);

    logic [TS_W-1:0]     ts_q, ts_d;
    logic [STATUS_W-1:0] status_prev_q;
    logic                overflow_q, overflow_d;
    logic [15:0]         drop_cnt_q, drop_cnt_d;
    logic                ts_wrap_q, ts_wrap_d;
    logic                fifo_full, fifo_empty;
    logic                evt, pop, push, drop;

    assign rd_vld_o = !fifo_empty;
    assign pop      = rd_vld_o && rd_rdy_i && !clear_i;
    assign evt      = enable_i && (status_i != status_prev_q) && !clear_i;
    assign push     = evt && (!fifo_full || pop);
    assign drop     = evt && fifo_full && !pop;

    always_comb begin
        ts_d       = ts_q;
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;
        ts_wrap_d  = ts_wrap_q;
        if (clear_i) begin
            ts_d       = '0;
            overflow_d = 1'b0;
            drop_cnt_d = '0;
            ts_wrap_d  = 1'b0;
        end else begin
            if (enable_i) begin
                ts_d = ts_q + 1'b1;
                if (&ts_q) ts_wrap_d = 1'b1;
            end
            if (drop) begin
                overflow_d = 1'b1;
                if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
            end
        end
    end

    // status_prev follows the input even while disabled or clearing, so a
    // held status never looks like a change once tracing resumes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts_q          <= '0;
            status_prev_q <= '0;
            overflow_q    <= 1'b0;
            drop_cnt_q    <= '0;
            ts_wrap_q     <= 1'b0;
        end else begin
            ts_q          <= ts_d;
            status_prev_q <= status_i;
            overflow_q    <= overflow_d;
            drop_cnt_q    <= drop_cnt_d;
            ts_wrap_q     <= ts_wrap_d;
        end
    end

    dbg_sync_fifo #(
        .WIDTH (DBG_WORD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (clear_i),
        .push_i  (push),
        .data_i  ({status_i, ts_q}),
        .pop_i   (pop),
        .data_o  (rd_data_o),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (count_o)
    );

    assign overflow_o = overflow_q;
    assign drop_cnt_o = drop_cnt_q;
    assign ts_wrap_o  = ts_wrap_q;

endmodule

// File: tb/tb_debug_trace_buffer.sv
// Directed and randomized checks of debug_trace_buffer against a queue-based reference model.
// A second narrow-timestamp instance exercises timestamp wrap.
module tb_debug_trace_buffer;
    import dbg_pkg::*;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  status;
    logic        enable, clear, rdy;
    logic        rd_vld;
    logic [31:0] rd_data;
    logic [4:0]  count;
    logic        overflow;
    logic [15:0] drop_cnt;
    logic        ts_wrap;

    logic [27:0] status2;
    logic        enable2, clear2, rdy2;
    logic        rd_vld2;
    logic [31:0] rd_data2;
    logic [2:0]  count2;
    logic        overflow2;
    logic [15:0] drop_cnt2;
    logic        ts_wrap2;

    int tests = 0;
    int failed = 0;

    // Reference model state
    int unsigned m_ts;
    logic [7:0]  m_prev;
    logic [31:0] q[$];
    bit          m_ov, m_wrap;
    int          m_drops;

    always #5 clk = ~clk;

    debug_trace_buffer #(.STATUS_W(8), .TS_W(24), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .status_i(status), .enable_i(enable), .clear_i(clear),
        .rd_vld_o(rd_vld), .rd_rdy_i(rdy), .rd_data_o(rd_data), .count_o(count),
        .overflow_o(overflow), .drop_cnt_o(drop_cnt), .ts_wrap_o(ts_wrap)
    );

    debug_trace_buffer #(.STATUS_W(28), .TS_W(4), .DEPTH(4)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .status_i(status2), .enable_i(enable2), .clear_i(clear2),
        .rd_vld_o(rd_vld2), .rd_rdy_i(rdy2), .rd_data_o(rd_data2), .count_o(count2),
        .overflow_o(overflow2), .drop_cnt_o(drop_cnt2), .ts_wrap_o(ts_wrap2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_ts = 0; m_prev = '0; m_ov = 0; m_wrap = 0; m_drops = 0;
    endtask

    // One clock of the behavioural rules, applied to the inputs seen at the edge.
    task automatic model_update();
        trace_entry_t e;
        if (clear) begin
            q.delete();
            m_ts = 0; m_ov = 0; m_drops = 0; m_wrap = 0;
        end else begin
            if (rdy && q.size() > 0) void'(q.pop_front());
            if (enable && status != m_prev) begin
                e.status = status;
                e.ts     = m_ts[23:0];
                if (q.size() < DEPTH) q.push_back(e);
                else begin
                    m_ov = 1;
                    if (m_drops < 65535) m_drops++;
                end
            end
            if (enable) begin
                if (m_ts == 32'h00FF_FFFF) m_wrap = 1;
                m_ts = (m_ts + 1) % (1 << 24);
            end
        end
        m_prev = status;
    endtask

    task automatic check_all();
        check("vld", {31'b0, rd_vld}, {31'b0, q.size() != 0});
        check("data", rd_data, (q.size() != 0) ? q[0] : 32'h0);
        check("count", {27'b0, count}, q.size());
        check("overflow", {31'b0, overflow}, {31'b0, m_ov});
        check("drop_cnt", {16'b0, drop_cnt}, m_drops);
        check("ts_wrap", {31'b0, ts_wrap}, {31'b0, m_wrap});
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        @(negedge clk);
        check_all();
    endtask

    initial begin
        logic [23:0] prev_ts;
        logic [23:0] frozen;
        rst_n = 1'b0; status = '0; enable = 0; clear = 0; rdy = 0;
        status2 = '0; enable2 = 0; clear2 = 0; rdy2 = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        check_all();
        check("rst_vld2", {31'b0, rd_vld2}, 32'h0);

        // 1: first event latency and entry format
        enable = 1;
        while (m_ts != 5) step();
        status = 8'h80;
        step();
        check("t1_data", rd_data, 32'h8000_0005);
        check("t1_count", {27'b0, count}, 32'd1);

        // 2: fill past full with the reader stalled, then drain in order
        rdy = 1; step(); rdy = 0;
        for (int i = 0; i < 17; i++) begin
            status = (status == 8'h80) ? 8'hC0 : 8'h80;
            step();
        end
        check("t2_count", {27'b0, count}, 32'd16);
        check("t2_ovf", {31'b0, overflow}, 32'd1);
        check("t2_drops", {16'b0, drop_cnt}, 32'd1);
        rdy = 1;
        prev_ts = '0;
        for (int i = 0; i < 16; i++) begin
            if (i > 0) check("t2_ts_incr", {31'b0, rd_data[23:0] > prev_ts}, 32'd1);
            prev_ts = rd_data[23:0];
            step();
        end
        check("t2_empty", {31'b0, rd_vld}, 32'd0);

        // 3: event coinciding with a pop while full is kept, not dropped
        rdy = 0; clear = 1; step(); clear = 0;
        for (int i = 0; i < 16; i++) begin
            status = (status == 8'h80) ? 8'hC0 : 8'h80;
            step();
        end
        rdy = 1; status = 8'h11; step(); rdy = 0;
        check("t3_count", {27'b0, count}, 32'd16);
        check("t3_ovf", {31'b0, overflow}, 32'd0);
        check("t3_tail_status", {24'b0, q[$][31:24]}, 32'h11);

        // 4: clear with a changed-but-then-stable status logs nothing
        status = 8'hFF; clear = 1; step(); clear = 0;
        check("t4_count", {27'b0, count}, 32'd0);
        check("t4_vld", {31'b0, rd_vld}, 32'd0);
        check("t4_ovf", {31'b0, overflow}, 32'd0);
        check("t4_drops", {16'b0, drop_cnt}, 32'd0);
        repeat (5) step();
        check("t4_stable", {27'b0, count}, 32'd0);

        // 5: changes while disabled are invisible and freeze the timestamp
        status = 8'h01; clear = 1; step(); clear = 0;
        repeat (3) step();
        frozen = m_ts[23:0];
        enable = 0;
        for (int i = 0; i < 10; i++) begin
            status = (i % 2 == 1) ? 8'h03 : 8'h01;
            step();
        end
        check("t5_dis_count", {27'b0, count}, 32'd0);
        enable = 1; step();
        check("t5_reen_count", {27'b0, count}, 32'd0);
        status = 8'h07; step();
        // one enabled cycle (the re-enable) has elapsed since the freeze
        check("t5_entry", rd_data, {8'h07, frozen + 24'd1});

        // randomized traffic with a mid-run asynchronous reset
        rdy = 0; clear = 1; step(); clear = 0;
        for (int i = 0; i < 400; i++) begin
            status = 8'h01 << $urandom_range(0, 3);
            enable = ($urandom % 8) != 0;
            rdy    = ($urandom % 3) == 0;
            clear  = ($urandom % 64) == 0;
            if (i == 200) begin
                rst_n = 1'b0;
                #1;
                model_reset();
                check_all();
                @(negedge clk);
                rst_n = 1'b1;
            end
            step();
        end
        clear = 0; enable = 0; rdy = 0;

        // 6: 4-bit timestamp wraps and its flag stays sticky until clear
        clear2 = 1; step(); clear2 = 0;
        enable2 = 1;
        for (int k = 1; k <= 20; k++) begin
            if (k == 18) status2 = 28'h1;
            step();
            check("t6_wrap", {31'b0, ts_wrap2}, {31'b0, k >= 16});
            if (k == 18) check("t6_entry", rd_data2, 32'h0000_0011);
        end
        clear2 = 1; step(); clear2 = 0;
        check("t6_wrap_clr", {31'b0, ts_wrap2}, 32'd0);
        check("t6_count_clr", {29'b0, count2}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
